// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle for both requester ports plus the
// single-port data memory connection.
//   p0_* : CPU load/store port       p1_* : debug/loader port
//   mem_*: data memory (combinational read, write on posedge)
// Modports:
//   slave  - arbiter view (takes requests, drives responses and memory)
//   master - environment view (drives requests, returns mem_rdata)
interface dmem_arbiter_if;
  logic        p0_valid, p0_ready, p0_we;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_valid, p1_ready, p1_we;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
// Port 0 (CPU) has priority over port 1 (debug). Each accepted request is
// registered, performs a one-cycle memory access, and returns a registered
// one-cycle response to its owner. Misaligned / out-of-range addresses get
// an error response and never strobe the memory.
// Ports:
//   clk  - clock (rising edge)
//   rst  - synchronous active-low reset
//   bus  - dmem_arbiter_if.slave (requests, responses, memory)
// Optional build macro:
//   DMEM_ARB_STARVE_EN - after STARVE_LIMIT consecutive waiting cycles,
//                        port 1 is promoted above port 0.
module dmem_arbiter #(
  parameter int MEM_WORDS    = 128,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              cmd_we_q;
  logic [31:0]       cmd_addr_q, cmd_wdata_q;
  logic [1:0]        rsp_valid_q, rsp_err_q;
  logic [1:0][31:0]  rsp_rdata_q;

  logic can_grant, p1_pri, gnt0, gnt1, hs0, hs1, hs, legal;

  // ready is held low while in reset so nothing is offered to requesters
  assign can_grant = rst && (state_q == IDLE || state_q == RESP);
  assign gnt0      = bus.p0_valid && !(p1_pri && bus.p1_valid);
  assign gnt1      = bus.p1_valid && !gnt0;
  assign hs0       = can_grant && gnt0;
  assign hs1       = can_grant && gnt1;
  assign hs        = hs0 || hs1;

  assign bus.p0_ready = hs0;
  assign bus.p1_ready = hs1;

  // word index compared unsigned with two zero bits on top, so no wrap
  assign legal = (cmd_addr_q[1:0] == 2'b00) &&
                 ({2'b00, cmd_addr_q[31:2]} < 32'(MEM_WORDS));

  // address/data come straight from the command register, which only
  // changes on a handshake, so they hold outside ACCESS
  assign bus.mem_read  = (state_q == ACCESS) && legal && !cmd_we_q;
  assign bus.mem_write = (state_q == ACCESS) && legal &&  cmd_we_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;

  assign bus.p0_rsp_valid = rsp_valid_q[0];
  assign bus.p0_rsp_err   = rsp_err_q[0];
  assign bus.p0_rsp_rdata = rsp_rdata_q[0];
  assign bus.p1_rsp_valid = rsp_valid_q[1];
  assign bus.p1_rsp_err   = rsp_err_q[1];
  assign bus.p1_rsp_rdata = rsp_rdata_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = hs ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q     <= hs1;
        cmd_we_q    <= hs1 ? bus.p1_we    : bus.p0_we;
        cmd_addr_q  <= hs1 ? bus.p1_addr  : bus.p0_addr;
        cmd_wdata_q <= hs1 ? bus.p1_wdata : bus.p0_wdata;
      end
      // response lives for exactly the RESP cycle; all fields zero otherwise
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
      if (state_q == ACCESS) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_err_q[owner_q]   <= !legal;
        rsp_rdata_q[owner_q] <= (legal && !cmd_we_q) ? bus.mem_rdata : 32'h0;
      end
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  // counts cycles port 1 waits (including ACCESS), saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!bus.p1_valid || hs1)              starve_d = '0;
    else if (starve_q < CW'(STARVE_LIMIT)) starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign p1_pri = (starve_q >= CW'(STARVE_LIMIT));
`else
  assign p1_pri = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   miss = 0;
  int   wr_cnt = 0;
  int   p0_gnts, p1_gnts;
  logic [31:0] mem [0:127];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_WORDS(128), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // memory model: combinational read, write on posedge
  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return {24'h0, bus.p0_ready, bus.p1_ready, bus.p0_rsp_valid, bus.p1_rsp_valid,
            bus.p0_rsp_err, bus.p1_rsp_err, bus.mem_read, bus.mem_write} |
           bus.p0_rsp_rdata | bus.p1_rsp_rdata | bus.mem_addr | bus.mem_wdata;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[2] = 32'hDEADBEEF;

    // ---- reset held 3 cycles with both ports requesting
    rst = 1'b0;
    bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8;  bus.p0_wdata = 32'h0;
    bus.p1_valid = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h10; bus.p1_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", all_out(), 32'h0);
    end

    // ---- legal read by p0 (handshake N)
    bus.p1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rd_p0_ready", {31'h0, bus.p0_ready}, 32'h1);
    step();                               // N+1: ACCESS
    bus.p0_valid = 1'b0;
    #1;
    chk("rd_mem_read", {31'h0, bus.mem_read}, 32'h1);
    chk("rd_mem_addr", bus.mem_addr, 32'h8);
    chk("rd_mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rd_no_rsp_early", {31'h0, bus.p0_rsp_valid}, 32'h0);
    step();                               // N+2: RESP
    chk("rd_rsp_valid", {31'h0, bus.p0_rsp_valid}, 32'h1);
    chk("rd_rsp_rdata", bus.p0_rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", {31'h0, bus.p0_rsp_err}, 32'h0);
    chk("rd_mem_read_off", {31'h0, bus.mem_read}, 32'h0);
    step();                               // IDLE
    chk("rd_rsp_one_cycle", {31'h0, bus.p0_rsp_valid}, 32'h0);

    // ---- p1 write then read of 0x10
    bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h10; bus.p1_wdata = 32'h12345678;
    #1;
    chk("wr_p1_ready", {31'h0, bus.p1_ready}, 32'h1);
    step();
    bus.p1_valid = 1'b0;
    #1;
    chk("wr_mem_write", {31'h0, bus.mem_write}, 32'h1);
    chk("wr_mem_addr", bus.mem_addr, 32'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
    step();                               // RESP of write
    chk("wr_rsp_valid", {31'h0, bus.p1_rsp_valid}, 32'h1);
    chk("wr_rsp_rdata", bus.p1_rsp_rdata, 32'h0);
    bus.p1_valid = 1'b1; bus.p1_we = 1'b0;
    #1;
    chk("wr_rd_ready_in_resp", {31'h0, bus.p1_ready}, 32'h1);
    step();
    bus.p1_valid = 1'b0;
    #1;
    chk("wr_rd_mem_read", {31'h0, bus.mem_read}, 32'h1);
    step();
    chk("wr_rd_rdata", bus.p1_rsp_rdata, 32'h12345678);
    chk("wr_rd_p1_valid", {31'h0, bus.p1_rsp_valid}, 32'h1);
    chk("wr_rd_p0_quiet", {31'h0, bus.p0_rsp_valid}, 32'h0);
    chk("wr_pulse_count", wr_cnt, 32'd1);
    step();

    // ---- contention from IDLE
    bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8;
    bus.p1_valid = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h10;
    #1;
    chk("ct_p0_ready_N", {30'h0, bus.p0_ready, bus.p1_ready}, 32'h2);
    step();                               // N+1 ACCESS
    bus.p0_valid = 1'b0;
    #1;
    chk("ct_no_ready_access", {30'h0, bus.p0_ready, bus.p1_ready}, 32'h0);
    step();                               // N+2 RESP
    chk("ct_p0_rsp", bus.p0_rsp_rdata, 32'hDEADBEEF);
    chk("ct_p1_ready_N2", {30'h0, bus.p0_ready, bus.p1_ready}, 32'h1);
    step();                               // N+3 ACCESS
    bus.p1_valid = 1'b0;
    step();                               // N+4 RESP
    chk("ct_p1_rsp_valid", {30'h0, bus.p0_rsp_valid, bus.p1_rsp_valid}, 32'h1);
    chk("ct_p1_rsp_rdata", bus.p1_rsp_rdata, 32'h12345678);
    step();

    // ---- illegal addresses: misaligned read, out-of-range write
    bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h6;
    #1;
    chk("il_rd_ready", {31'h0, bus.p0_ready}, 32'h1);
    step();
    bus.p0_valid = 1'b0;
    #1;
    chk("il_rd_no_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    step();
    chk("il_rd_rsp", {29'h0, bus.p0_rsp_valid, bus.p0_rsp_err, bus.p1_rsp_valid}, 32'h6);
    chk("il_rd_rdata", bus.p0_rsp_rdata, 32'h0);
    bus.p0_valid = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h200; bus.p0_wdata = 32'hCAFEF00D;
    #1;
    chk("il_wr_ready", {31'h0, bus.p0_ready}, 32'h1);
    step();
    bus.p0_valid = 1'b0;
    #1;
    chk("il_wr_no_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    step();
    chk("il_wr_rsp", {30'h0, bus.p0_rsp_valid, bus.p0_rsp_err}, 32'h3);
    chk("il_wr_rdata", bus.p0_rsp_rdata, 32'h0);
    chk("il_wr_count", wr_cnt, 32'd1);
    chk("il_mem0_intact", mem[0], 32'h1000_0000);
    step();

    // ---- starvation: both held valid for 30 cycles starting in IDLE
    p0_gnts = 0; p1_gnts = 0;
    bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8;
    bus.p1_valid = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h10;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.p0_ready) p0_gnts++;
      if (bus.p1_ready) p1_gnts++;
      step();
    end
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    chk("sv_p1_promoted", {31'h0, (p1_gnts > 0)}, 32'h1);
`else
    chk("sv_p1_starved", p1_gnts, 32'd0);
    chk("sv_p0_grants", p0_gnts, 32'd15);
`endif
    step(); step(); step();

    // ---- reset during ACCESS drops the transaction
    bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h8;
    #1;
    chk("rm_ready", {31'h0, bus.p0_ready}, 32'h1);
    step();
    bus.p0_valid = 1'b0;
    #1;
    chk("rm_access", {31'h0, bus.mem_read}, 32'h1);
    rst = 1'b0;
    step();
    chk("rm_strobe_drop", {30'h0, bus.mem_read, bus.p0_rsp_valid}, 32'h0);
    rst = 1'b1;
    step();
    chk("rm_no_rsp", {30'h0, bus.p0_rsp_valid, bus.p1_rsp_valid}, 32'h0);
    bus.p0_valid = 1'b1;
    #1;
    chk("rm_idle_ready", {31'h0, bus.p0_ready}, 32'h1);
    bus.p0_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
